truth_table_checker: RTL and testbench

- Sequential response checker for the 4-input/3-output logic block (r1 = x | ~y&z, r2 = its DeMorgan form, r3 = wxyz | w'x'y'z').
- On `start`, it walks all 16 input rows and drives each onto the block under test.
- For each row it waits a settle time, samples the three responses and compares them with an internal golden model.
- It reports a mismatch count and the first failing row. This is the hardware reader/checker counterpart of the stimulus side, usable on-board or in regression.

---
 rtl/tt_pkg.sv | 23 ++
 rtl/tt_golden.sv | 23 ++
 rtl/truth_table_checker.sv | 140 ++++++++++++++
 tb/tb_truth_table_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table response checker.
package tt_pkg;

  localparam int unsigned NUM_ROWS  = 16;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned ROW_CNT_W = 5;
  localparam int unsigned RESP_W    = 3;
  localparam int unsigned ERR_W     = 5;
  localparam int unsigned CNT_W     = 8;

  // Response bit positions on dut_resp / expected vectors
  localparam int unsigned R1 = 0;
  localparam int unsigned R2 = 1;
  localparam int unsigned R3 = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/tt_golden.sv
// Combinational golden model of the 4-in/3-out logic block.
module tt_golden
  import tt_pkg::*;
(
  input  logic [ROW_W-1:0]  row,
  output logic [RESP_W-1:0] expected_c
);

  logic w, x, y, z;

  // Row bits: [3]=w, [2]=x, [1]=y, [0]=z
  always_comb begin
    w = row[3];
    x = row[2];
    y = row[1];
    z = row[0];
    expected_c     = '0;
    expected_c[R1] = x | (~y & z);
    expected_c[R2] = ~(~x & ~(~y & z));
    expected_c[R3] = (w & x & y & z) | (~w & ~x & ~y & ~z);
  end

endmodule

// File: rtl/truth_table_checker.sv
// Sweeps all 16 input rows onto a block under test and checks its responses.
module truth_table_checker
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter bit          STOP_ON_FAIL  = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ROW_W-1:0]  dut_in,
  input  logic [RESP_W-1:0] dut_resp,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ROW_W-1:0]  first_fail_row,
  output logic [RESP_W-1:0] first_fail_bits,
  output logic              sample_valid,
  output logic [ROW_W-1:0]  sample_row
);

  localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ROW_CNT_W-1:0] LAST_ROW    = ROW_CNT_W'(NUM_ROWS - 1);

  state_e               state_q, state_d;
  logic [ROW_CNT_W-1:0] row_q, row_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ROW_W-1:0]     dut_in_d;
  logic                 busy_d, done_d, pass_d;
  logic [ERR_W-1:0]     err_d;
  logic [ROW_W-1:0]     ffr_d;
  logic [RESP_W-1:0]    ffb_d;
  logic                 sv_d;
  logic [ROW_W-1:0]     sr_d;
  logic [RESP_W-1:0]    expected_c;
  logic [RESP_W-1:0]    mismatch_c;

  tt_golden u_golden (
    .row        (ROW_W'(row_q)),
    .expected_c (expected_c)
  );

  assign mismatch_c = expected_c ^ dut_resp;

  // Next-state and next-output computation
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    dut_in_d = dut_in;
    busy_d   = busy;
    done_d   = done;
    pass_d   = pass;
    err_d    = err_count;
    ffr_d    = first_fail_row;
    ffb_d    = first_fail_bits;
    sv_d     = 1'b0;
    sr_d     = sample_row;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          row_d    = '0;
          cnt_d    = '0;
          dut_in_d = '0;
          err_d    = '0;
          ffr_d    = '0;
          ffb_d    = '0;
          pass_d   = 1'b0;
          done_d   = 1'b0;
          busy_d   = 1'b1;
          state_d  = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          sv_d    = 1'b1;
          sr_d    = ROW_W'(row_q);
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (mismatch_c != '0) begin
          err_d = err_count + ERR_W'(1);
          if (err_count == '0) begin
            ffr_d = ROW_W'(row_q);
            ffb_d = mismatch_c;
          end
        end
        if ((row_q == LAST_ROW) || (STOP_ON_FAIL && (mismatch_c != '0))) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
          state_d = ST_DONE;
        end else begin
          row_d    = row_q + ROW_CNT_W'(1);
          dut_in_d = ROW_W'(row_q + ROW_CNT_W'(1));
          cnt_d    = '0;
          state_d  = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      row_q           <= '0;
      cnt_q           <= '0;
      dut_in          <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      err_count       <= '0;
      first_fail_row  <= '0;
      first_fail_bits <= '0;
      sample_valid    <= 1'b0;
      sample_row      <= '0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      cnt_q           <= cnt_d;
      dut_in          <= dut_in_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      err_count       <= err_d;
      first_fail_row  <= ffr_d;
      first_fail_bits <= ffb_d;
      sample_valid    <= sv_d;
      sample_row      <= sr_d;
    end
  end

endmodule

// File: tb/tb_truth_table_checker.sv
// Bench for truth_table_checker: three parameterisations, fault-injected responses.
module tb_truth_table_checker;

  localparam int NI = 3;
  localparam int M_CLEAN = 0;
  localparam int M_R3SA0 = 1;
  localparam int M_R1INV = 2;
  localparam int M_R2SA1 = 3;

  typedef struct {
    int k;
    int mode;
    int err;
    int ffr;
    int ffb;
    int last;
    int restart;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start        [NI];
  logic [3:0] dut_in       [NI];
  logic [2:0] dut_resp     [NI];
  logic       busy         [NI];
  logic       done         [NI];
  logic       pass         [NI];
  logic [4:0] err_count    [NI];
  logic [3:0] ffr          [NI];
  logic [2:0] ffb          [NI];
  logic       sample_valid [NI];
  logic [3:0] sample_row   [NI];
  logic [2:0] mask         [NI][16];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Instance 0: defaults; 1: stop on first failure; 2: one-cycle settle
  for (genvar g = 0; g < NI; g++) begin : g_dut
    truth_table_checker #(
      .SETTLE_CYCLES ((g == 2) ? 1 : 4),
      .STOP_ON_FAIL  (g == 1)
    ) u_dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start           (start[g]),
      .dut_in          (dut_in[g]),
      .dut_resp        (dut_resp[g]),
      .busy            (busy[g]),
      .done            (done[g]),
      .pass            (pass[g]),
      .err_count       (err_count[g]),
      .first_fail_row  (ffr[g]),
      .first_fail_bits (ffb[g]),
      .sample_valid    (sample_valid[g]),
      .sample_row      (sample_row[g])
    );
  end

  // Reference behaviour of the logic block from its boolean definition
  function automatic logic [2:0] gold(input logic [3:0] r);
    int  v;
    bit  x, y, z, r1, r3;
    v  = int'(r);
    x  = r[2];
    y  = r[1];
    z  = r[0];
    r1 = x || (!y && z);
    r3 = (v == 0) || (v == 15);
    return {r3, r1, r1};
  endfunction

  // Emulated block under test: golden behaviour with per-row fault XOR
  always_comb begin
    for (int k = 0; k < NI; k++) dut_resp[k] = gold(dut_in[k]) ^ mask[k][dut_in[k]];
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_mode(input int k, input int mode);
    logic [2:0] g;
    for (int r = 0; r < 16; r++) begin
      g = gold(4'(r));
      case (mode)
        M_R3SA0: mask[k][r] = {g[2], 2'b00};
        M_R1INV: mask[k][r] = 3'b001;
        M_R2SA1: mask[k][r] = {1'b0, ~g[1], 1'b0};
        default: mask[k][r] = 3'b000;
      endcase
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    check({tag, "_busy"}, int'(busy[k]), 0);
    check({tag, "_done"}, int'(done[k]), 0);
    check({tag, "_pass"}, int'(pass[k]), 0);
    check({tag, "_err"}, int'(err_count[k]), 0);
    check({tag, "_ffr"}, int'(ffr[k]), 0);
    check({tag, "_ffb"}, int'(ffb[k]), 0);
    check({tag, "_sv"}, int'(sample_valid[k]), 0);
    check({tag, "_sr"}, int'(sample_row[k]), 0);
    check({tag, "_dut_in"}, int'(dut_in[k]), 0);
  endtask

  // Start a sweep on instance k and check the whole run against expectations
  task automatic sweep(input int k, input int exp_err, input int exp_ffr, input int exp_ffb,
                       input int exp_last, input int restart_at, input string tag);
    int s;
    int exp_edge;
    int cyc;
    int strobes;
    bit rows_ok;
    bit busy_ok;
    s        = (k == 2) ? 1 : 4;
    exp_edge = (exp_last + 1) * (s + 1);
    cyc      = 0;
    strobes  = 0;
    rows_ok  = 1'b1;
    busy_ok  = 1'b1;
    @(negedge clk);
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    start[k] = 1'b0;
    check({tag, "_acc_busy"}, int'(busy[k]), 1);
    check({tag, "_acc_done"}, int'(done[k]), 0);
    check({tag, "_acc_err"}, int'(err_count[k]), 0);
    check({tag, "_acc_pass"}, int'(pass[k]), 0);
    check({tag, "_acc_dut_in"}, int'(dut_in[k]), 0);
    while (!done[k] && cyc < 300) begin
      @(negedge clk);
      start[k] = (cyc == restart_at);
      if (!busy[k]) busy_ok = 1'b0;
      if (sample_valid[k]) begin
        if (int'(sample_row[k]) != strobes || int'(dut_in[k]) != strobes) rows_ok = 1'b0;
        strobes++;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    start[k] = 1'b0;
    check({tag, "_done_edge"}, cyc, exp_edge);
    check({tag, "_strobes"}, strobes, exp_last + 1);
    check({tag, "_row_seq"}, int'(rows_ok), 1);
    check({tag, "_busy_held"}, int'(busy_ok), 1);
    check({tag, "_busy_end"}, int'(busy[k]), 0);
    check({tag, "_err"}, int'(err_count[k]), exp_err);
    check({tag, "_pass"}, int'(pass[k]), (exp_err == 0) ? 1 : 0);
    check({tag, "_dut_in_end"}, int'(dut_in[k]), exp_last);
    if (exp_err != 0) begin
      check({tag, "_ffr"}, int'(ffr[k]), exp_ffr);
      check({tag, "_ffb"}, int'(ffb[k]), exp_ffb);
    end
    @(posedge clk);
    #1;
    check({tag, "_done_hold"}, int'(done[k]), 1);
    check({tag, "_busy_hold"}, int'(busy[k]), 0);
  endtask

  // Expected result of a sweep given the injected fault pattern
  task automatic model(input int k, output int err, output int f_row, output int f_bits,
                       output int last);
    bit stop;
    stop   = (k == 1);
    err    = 0;
    f_row  = 0;
    f_bits = 0;
    last   = 15;
    for (int r = 0; r < 16; r++) begin
      if (mask[k][r] != 3'b000) begin
        if (err == 0) begin
          f_row  = r;
          f_bits = int'(mask[k][r]);
        end
        err++;
        if (stop) begin
          last = r;
          break;
        end
      end
    end
  endtask

  vec_t vecs[8];

  initial begin
    int e, fr, fb, la;
    vecs[0] = '{0, M_CLEAN, 0, 0, 0, 15, -1};
    vecs[1] = '{0, M_R3SA0, 2, 0, 4, 15, -1};
    vecs[2] = '{0, M_R1INV, 16, 0, 1, 15, 20};
    vecs[3] = '{1, M_R2SA1, 1, 0, 2, 0, 4};
    vecs[4] = '{1, M_R3SA0, 1, 0, 4, 0, -1};
    vecs[5] = '{1, M_CLEAN, 0, 0, 0, 15, -1};
    vecs[6] = '{2, M_R1INV, 16, 0, 1, 15, -1};
    vecs[7] = '{2, M_CLEAN, 0, 0, 0, 15, -1};

    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      start[k] = 1'b0;
      set_mode(k, M_CLEAN);
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check_idle(k, $sformatf("reset%0d", k));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed fault table
    for (int i = 0; i < 8; i++) begin
      set_mode(vecs[i].k, vecs[i].mode);
      sweep(vecs[i].k, vecs[i].err, vecs[i].ffr, vecs[i].ffb, vecs[i].last,
            vecs[i].restart, $sformatf("vec%0d", i));
    end

    // Asynchronous reset while row 7 is settling, then a clean full sweep
    set_mode(0, M_R1INV);
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (37) @(posedge clk);
    #2;
    check("midrst_row7", int'(dut_in[0]), 7);
    check("midrst_busy", int'(busy[0]), 1);
    check("midrst_err", int'(err_count[0]), 7);
    rst_n = 1'b0;
    #1;
    check_idle(0, "midrst");
    @(negedge clk);
    rst_n = 1'b1;
    set_mode(0, M_CLEAN);
    sweep(0, 0, 0, 0, 15, -1, "after_rst");

    // Random fault patterns checked against the row-level model
    for (int it = 0; it < 9; it++) begin
      int k;
      k = it % NI;
      for (int r = 0; r < 16; r++)
        mask[k][r] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      model(k, e, fr, fb, la);
      sweep(k, e, fr, fb, la, -1, $sformatf("rnd%0d", it));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
